// File: rtl/mcu_test_capture.sv
// Post-trigger capture buffer for the MCU 32-bit observation word.
// Arms on request, triggers on a masked compare, records up to DEPTH samples and serves registered reads.
module mcu_test_capture #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [31:0]   mcu_test_out,
  input  logic          arm,
  input  logic          abort,
  input  logic [31:0]   trig_mask,
  input  logic [31:0]   trig_value,
  input  logic          chg_only,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic [1:0]    cap_state,
  output logic [AW:0]   cap_cnt,
  output logic          cap_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_t        state;
  logic [31:0]   last_stored;
  logic [31:0]   mem [DEPTH];
  logic          trig_hit;
  logic          keep_sample;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   next_cnt;
  logic          rd_hit;

  assign trig_hit    = ((mcu_test_out ^ trig_value) & trig_mask) == 32'h0;
  assign keep_sample = !chg_only || (mcu_test_out != last_stored);
  assign next_cnt    = cap_cnt + CNT_ONE;
  assign rd_hit      = {1'b0, rd_addr} < cap_cnt;
  assign cap_state   = state;

  // Single write port; reset and abort both suppress the store of the current sample.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    if (!sys_rst && !abort) begin
      case (state)
        ARMED: wr_en = trig_hit;
        CAPT: begin
          wr_en   = keep_sample;
          wr_addr = cap_cnt[AW-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      cap_cnt     <= '0;
      cap_done    <= 1'b0;
      last_stored <= 32'h0;
    end else if (abort) begin
      state    <= IDLE;
      cap_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state   <= ARMED;
            cap_cnt <= '0;
          end
        end
        ARMED: begin
          if (trig_hit) begin
            state       <= CAPT;
            cap_cnt     <= CNT_ONE;
            last_stored <= mcu_test_out;
          end
        end
        CAPT: begin
          // cap_cnt never exceeds DEPTH-1 here, so the write address cannot wrap.
          if (keep_sample) begin
            cap_cnt     <= next_cnt;
            last_stored <= mcu_test_out;
            if (next_cnt == CNT_FULL) begin
              state    <= DONE;
              cap_done <= 1'b1;
            end
          end
        end
        DONE: begin
          if (arm) begin
            state    <= ARMED;
            cap_cnt  <= '0;
            cap_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= mcu_test_out;
    end
  end

  // Entries at or beyond the stored count read as zero, including one being written this cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_valid <= 1'b0;
      rd_data  <= 32'h0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rd_hit ? mem[rd_addr] : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mcu_test_capture.sv
// Directed self-checking bench for mcu_test_capture.
// Expected read data is queued when a read is issued and popped when rd_valid returns.
module tb_mcu_test_capture;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [31:0]   mcu_test_out;
  logic          arm;
  logic          abort;
  logic [31:0]   trig_mask;
  logic [31:0]   trig_value;
  logic          chg_only;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [1:0]    cap_state;
  logic [AW:0]   cap_cnt;
  logic          cap_done;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  mcu_test_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .mcu_test_out (mcu_test_out),
    .arm          (arm),
    .abort        (abort),
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
    .chg_only     (chg_only),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .cap_state    (cap_state),
    .cap_cnt      (cap_cnt),
    .cap_done     (cap_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] sample, input logic arm_v, input logic abort_v);
    mcu_test_out = sample;
    arm          = arm_v;
    abort        = abort_v;
    tick();
    arm   = 1'b0;
    abort = 1'b0;
  endtask

  task automatic checkState(input string tag, input int st, input int cnt, input int done);
    checkOutput({tag, "_state"}, 32'(cap_state), 32'(st));
    checkOutput({tag, "_cnt"}, 32'(cap_cnt), 32'(cnt));
    checkOutput({tag, "_done"}, 32'(cap_done), 32'(done));
  endtask

  task automatic issueRead(input int addr, input logic [31:0] expected);
    rd_req  = 1'b1;
    rd_addr = AW'(addr);
    exp_q.push_back(expected);
  endtask

  task automatic checkRead(input string tag);
    rd_req = 1'b0;
    checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s observed=%h expected=<scoreboard empty>", tag, rd_data);
    end else begin
      checkOutput(tag, rd_data, exp_q.pop_front());
    end
  endtask

  task automatic readAt(input string tag, input int addr, input logic [31:0] expected);
    issueRead(addr, expected);
    applyStimulus(mcu_test_out, 1'b0, 1'b0);
    checkRead(tag);
  endtask

  initial begin
    // Reset with arbitrary inputs, including a pending read and arm.
    sys_rst      = 1'b1;
    mcu_test_out = $urandom;
    trig_mask    = $urandom;
    trig_value   = $urandom;
    chg_only     = 1'b1;
    arm          = 1'b1;
    abort        = 1'b0;
    rd_req       = 1'b1;
    rd_addr      = AW'($urandom_range(0, DEPTH - 1));
    tick();
    tick();
    checkState("reset", 0, 0, 0);
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_rd_data", rd_data, 32'h0);
    sys_rst = 1'b0;
    rd_req  = 1'b0;
    arm     = 1'b0;

    // Basic capture on a ramp; upper bits of the compare value are masked off.
    $display("[TB] basic capture");
    trig_mask  = 32'h0000_00FF;
    trig_value = 32'hDEAD_003C;
    chg_only   = 1'b0;
    applyStimulus(32'h0, 1'b1, 1'b0);
    checkState("armed", 1, 0, 0);
    for (int i = 1; i < 32'h3C; i++) applyStimulus(32'(i), 1'b0, 1'b0);
    checkState("pre_trig", 1, 0, 0);
    applyStimulus(32'h3C, 1'b0, 1'b0);
    checkState("trig", 2, 1, 0);
    for (int i = 32'h3D; i <= 32'h4A; i++) applyStimulus(32'(i), 1'b0, 1'b0);
    checkState("cnt15", 2, 15, 0);
    applyStimulus(32'h4B, 1'b0, 1'b0);
    checkState("full", 3, 16, 1);
    applyStimulus(32'h4C, 1'b0, 1'b0);
    checkState("frozen", 3, 16, 1);
    for (int a = 0; a < DEPTH; a++) begin
      issueRead(a, 32'h3C + 32'(a));
      applyStimulus(mcu_test_out, 1'b0, 1'b0);
      checkRead($sformatf("basic_rd%0d", a));
    end
    applyStimulus(mcu_test_out, 1'b0, 1'b0);
    checkOutput("idle_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("hold_rd_data", rd_data, 32'h4B);

    // Arm from DONE, then a change-only capture with an arm pulse ignored in CAPT.
    $display("[TB] change-only capture");
    applyStimulus(32'h0, 1'b1, 1'b0);
    checkState("rearm", 1, 0, 0);
    trig_mask  = 32'hFFFF_FFFF;
    trig_value = 32'hA;
    chg_only   = 1'b1;
    applyStimulus(32'h5, 1'b0, 1'b0);
    applyStimulus(32'hA, 1'b0, 1'b0);
    applyStimulus(32'hA, 1'b0, 1'b0);
    applyStimulus(32'hB, 1'b0, 1'b0);
    applyStimulus(32'hB, 1'b1, 1'b0);
    applyStimulus(32'hB, 1'b0, 1'b0);
    applyStimulus(32'hC, 1'b0, 1'b0);
    applyStimulus(32'hC, 1'b0, 1'b0);
    applyStimulus(32'hD, 1'b0, 1'b0);
    checkState("chg", 2, 4, 0);
    readAt("chg_rd0", 0, 32'hA);
    readAt("chg_rd1", 1, 32'hB);
    readAt("chg_rd2", 2, 32'hC);
    readAt("chg_rd3", 3, 32'hD);
    readAt("chg_rd4", 4, 32'h0);
    applyStimulus(32'hE, 1'b0, 1'b1);
    checkState("chg_abort", 0, 4, 0);

    // Partial capture ended by abort colliding with arm.
    $display("[TB] abort with partial capture");
    chg_only   = 1'b0;
    trig_mask  = 32'hFFFF_0000;
    trig_value = 32'h1234_0000;
    applyStimulus(32'h0, 1'b1, 1'b0);
    applyStimulus(32'h1111_0000, 1'b0, 1'b0);
    checkState("part_armed", 1, 0, 0);
    applyStimulus(32'h1234_0007, 1'b0, 1'b0);
    for (int i = 32'h50; i <= 32'h53; i++) applyStimulus(32'(i), 1'b0, 1'b0);
    checkState("part5", 2, 5, 0);
    applyStimulus(32'h1234_0099, 1'b1, 1'b1);
    checkState("part_abort", 0, 5, 0);
    readAt("part_rd4", 4, 32'h53);
    readAt("part_rd7", 7, 32'h0);
    readAt("part_rd0", 0, 32'h1234_0007);

    // Always-match trigger plus reads of the entry being written.
    $display("[TB] always-match trigger");
    trig_mask = 32'h0;
    applyStimulus(32'hCAFE_0000, 1'b1, 1'b0);
    issueRead(0, 32'h0);
    applyStimulus(32'hCAFE_0001, 1'b0, 1'b0);
    checkRead("wr_collide0");
    checkState("am_trig", 2, 1, 0);
    issueRead(1, 32'h0);
    applyStimulus(32'hCAFE_0002, 1'b0, 1'b0);
    checkRead("wr_collide1");
    issueRead(0, 32'hCAFE_0001);
    applyStimulus(32'hCAFE_0003, 1'b1, 1'b0);
    checkRead("am_rd0");
    checkState("arm_in_capt", 2, 3, 0);
    applyStimulus(32'hCAFE_0004, 1'b0, 1'b1);
    checkState("am_abort", 0, 3, 0);
    readAt("am_rd2", 2, 32'hCAFE_0003);

    // Abort in ARMED suppresses a matching trigger.
    $display("[TB] abort while armed");
    trig_mask  = 32'hFFFF_FFFF;
    trig_value = 32'h77;
    applyStimulus(32'h0, 1'b1, 1'b0);
    applyStimulus(32'h77, 1'b0, 1'b1);
    checkState("armed_abort", 0, 0, 0);
    applyStimulus(32'h77, 1'b0, 1'b0);
    checkState("idle_no_trig", 0, 0, 0);

    // Reset mid-capture abandons the capture.
    $display("[TB] reset mid-capture");
    applyStimulus(32'h0, 1'b1, 1'b0);
    applyStimulus(32'h77, 1'b0, 1'b0);
    checkState("pre_rst", 2, 1, 0);
    sys_rst = 1'b1;
    applyStimulus(32'h78, 1'b0, 1'b0);
    sys_rst = 1'b0;
    checkState("mid_rst", 0, 0, 0);
    readAt("rst_rd0", 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
